// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, fetch FSM states and the fetch hold-buffer payload.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Instruction and its PC+4, captured together when IF/ID cannot accept.
    typedef struct packed {
        word_t instr;
        word_t pc_add4;
    } hold_entry_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// 64-bit capture register holding a fetched instruction and its PC+4 while the pipeline is stalled.
module fetch_hold_buf
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        load,
    input  logic        clear,
    input  hold_entry_t d,
    output hold_entry_t q
);

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem reads, applies redirects/stalls/halt.
// Build option: IF_HOLD_BUFFER_EN adds the HOLD state and a capture buffer for stalled fetches.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
)
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  dhit,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output logic  iREN,
    output word_t imemaddr,
    output word_t instruction,
    output word_t pc_add4,
    output logic  fetch_valid
);

    fetch_state_t state, state_nxt;
    word_t        pc, pc_nxt;
    word_t        pc_plus4;
    logic         kill;
    logic         advance;

`ifdef IF_HOLD_BUFFER_EN
    logic        buf_load;
    logic        buf_clr;
    hold_entry_t buf_d;
    hold_entry_t buf_q;

    fetch_hold_buf u_hold_buf (
        .CLK   (CLK),
        .RST   (RST),
        .load  (buf_load),
        .clear (buf_clr),
        .d     (buf_d),
        .q     (buf_q)
    );
`endif

    assign pc_plus4 = pc + 32'd4;
    // A redirect or halt squashes whatever is presented this cycle.
    assign kill     = halt | redirect;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            pc    <= PC_INIT;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        iREN        = 1'b0;
        imemaddr    = pc;
        instruction = '0;
        pc_add4     = pc_plus4;
        fetch_valid = 1'b0;
        advance     = 1'b0;
`ifdef IF_HOLD_BUFFER_EN
        buf_load    = 1'b0;
        buf_clr     = 1'b0;
        buf_d       = '{instr: imemload, pc_add4: pc_plus4};
`endif

        case (state)
            RUN: begin
                iREN        = 1'b1;
                fetch_valid = ihit & ~kill;
                instruction = fetch_valid ? imemload : '0;
            end
`ifdef IF_HOLD_BUFFER_EN
            HOLD: begin
                fetch_valid = ~kill;
                instruction = fetch_valid ? buf_q.instr : '0;
                pc_add4     = buf_q.pc_add4;
            end
`endif
            default: begin
            end
        endcase

        advance = fetch_valid & ~stall & ~dhit;

        // Priority: halt > redirect > advance/capture; HALTED is left only by reset.
        if (halt) begin
            state_nxt = HALTED;
        end else if (state != HALTED) begin
            if (redirect) begin
                pc_nxt    = redirect_pc;
                state_nxt = RUN;
`ifdef IF_HOLD_BUFFER_EN
                buf_clr   = 1'b1;
`endif
            end else if (advance) begin
                pc_nxt    = pc_plus4;
                state_nxt = RUN;
            end
`ifdef IF_HOLD_BUFFER_EN
            else if (state == RUN && ihit) begin
                buf_load  = 1'b1;
                state_nxt = HOLD;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; expectations adapt to IF_HOLD_BUFFER_EN.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam word_t K = 32'hA5A5_0000;

    logic  CLK = 1'b0;
    logic  RST;
    logic  ihit;
    word_t imemload;
    logic  dhit;
    logic  stall;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    logic  iREN;
    word_t imemaddr;
    word_t instruction;
    word_t pc_add4;
    logic  fetch_valid;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .imemload    (imemload),
        .dhit        (dhit),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .iREN        (iREN),
        .imemaddr    (imemaddr),
        .instruction (instruction),
        .pc_add4     (pc_add4),
        .fetch_valid (fetch_valid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic i_hit, input word_t load, input logic i_stall,
                         input logic i_dhit, input logic i_redir, input word_t rpc,
                         input logic i_halt);
        ihit        = i_hit;
        imemload    = load;
        stall       = i_stall;
        dhit        = i_dhit;
        redirect    = i_redir;
        redirect_pc = rpc;
        halt        = i_halt;
        #1;
    endtask

    initial begin
        RST = 1'b1;
        drive(0, '0, 0, 0, 0, '0, 0);
        tick();
        RST = 1'b0;
        #1;
        chk("rst_iren", 32'(iREN), 32'd1);
        chk("rst_addr", imemaddr, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        tick();

        // Streaming fetch with no stalls
        for (int i = 0; i < 2; i++) begin
            drive(1, word_t'(i * 4) ^ K, 0, 0, 0, '0, 0);
            chk("run_addr", imemaddr, word_t'(i * 4));
            chk("run_instr", instruction, word_t'(i * 4) ^ K);
            chk("run_add4", pc_add4, word_t'(i * 4 + 4));
            chk("run_valid", 32'(fetch_valid), 32'd1);
            tick();
        end

        // Stall at PC=8 for three cycles
        drive(1, 32'h8 ^ K, 1, 0, 0, '0, 0);
        chk("st0_valid", 32'(fetch_valid), 32'd1);
        chk("st0_instr", instruction, 32'h8 ^ K);
        chk("st0_addr", imemaddr, 32'h8);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h8 ^ K, 1, 0, 0, '0, 0);
`ifdef IF_HOLD_BUFFER_EN
            chk("hold_iren", 32'(iREN), 32'd0);
            chk("hold_instr", instruction, 32'h8 ^ K);
            chk("hold_add4", pc_add4, 32'hC);
`else
            chk("refetch_iren", 32'(iREN), 32'd1);
            chk("refetch_addr", imemaddr, 32'h8);
`endif
            chk("st_valid", 32'(fetch_valid), 32'd1);
            tick();
        end
        drive(1, 32'h8 ^ K, 0, 0, 0, '0, 0);
        chk("rel_valid", 32'(fetch_valid), 32'd1);
        chk("rel_instr", instruction, 32'h8 ^ K);
        chk("rel_add4", pc_add4, 32'hC);
        tick();
        drive(0, '0, 0, 0, 0, '0, 0);
        chk("adv_addr", imemaddr, 32'hC);
        chk("adv_iren", 32'(iREN), 32'd1);
        chk("nohit_valid", 32'(fetch_valid), 32'd0);
        chk("nohit_instr", instruction, 32'h0);
        tick();

        // Stall and dhit together, then redirect to 0x40
        drive(1, 32'hC ^ K, 1, 1, 0, '0, 0);
        chk("sd_valid", 32'(fetch_valid), 32'd1);
        tick();
        drive(1, 32'hC ^ K, 0, 0, 1, 32'h40, 0);
        chk("redir_valid", 32'(fetch_valid), 32'd0);
        chk("redir_instr", instruction, 32'h0);
        tick();
        drive(0, '0, 0, 0, 0, '0, 0);
        chk("redir_addr", imemaddr, 32'h40);
        chk("redir_iren", 32'(iREN), 32'd1);
        chk("redir_nv", 32'(fetch_valid), 32'd0);
        tick();

        // PC wraparound
        drive(0, '0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        tick();
        drive(1, 32'hFFFF_FFFC ^ K, 0, 0, 0, '0, 0);
        chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
        chk("wrap_add4", pc_add4, 32'h0);
        chk("wrap_instr", instruction, 32'hFFFF_FFFC ^ K);
        tick();
        drive(0, '0, 0, 0, 0, '0, 0);
        chk("wrap_next", imemaddr, 32'h0);
        tick();

        // Halt with a simultaneous redirect
        drive(1, K, 1, 0, 0, '0, 0);
        tick();
        drive(1, K, 0, 0, 1, 32'h80, 1);
        chk("halt_valid", 32'(fetch_valid), 32'd0);
        chk("halt_instr", instruction, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, K, 0, 0, 0, '0, 0);
            chk("hlt_iren", 32'(iREN), 32'd0);
            chk("hlt_valid", 32'(fetch_valid), 32'd0);
            chk("hlt_instr", instruction, 32'h0);
            chk("hlt_addr", imemaddr, 32'h0);
            tick();
        end
        drive(1, K, 0, 0, 1, 32'h80, 0);
        tick();
        chk("hlt_redir_addr", imemaddr, 32'h0);
        chk("hlt_redir_iren", 32'(iREN), 32'd0);

        // Reset out of HALTED
        RST = 1'b1;
        tick();
        RST = 1'b0;
        drive(1, K, 0, 0, 0, '0, 0);
        chk("unhalt_iren", 32'(iREN), 32'd1);
        chk("unhalt_addr", imemaddr, 32'h0);
        chk("unhalt_valid", 32'(fetch_valid), 32'd1);
        tick();

        // Reset while stalled (HOLD when the buffer is built in)
        drive(1, 32'h4 ^ K, 1, 0, 0, '0, 0);
        chk("pre_addr", imemaddr, 32'h4);
        tick();
        drive(0, '0, 1, 0, 0, '0, 0);
`ifdef IF_HOLD_BUFFER_EN
        chk("midhold_valid", 32'(fetch_valid), 32'd1);
        chk("midhold_instr", instruction, 32'h4 ^ K);
`else
        chk("midstall_valid", 32'(fetch_valid), 32'd0);
`endif
        RST = 1'b1;
        tick();
        RST = 1'b0;
        drive(0, '0, 0, 0, 0, '0, 0);
        chk("rst2_addr", imemaddr, 32'h0);
        chk("rst2_iren", 32'(iREN), 32'd1);
        chk("rst2_valid", 32'(fetch_valid), 32'd0);
        chk("rst2_instr", instruction, 32'h0);
        drive(1, K, 0, 0, 0, '0, 0);
        chk("rst2_hit_valid", 32'(fetch_valid), 32'd1);
        chk("rst2_hit_instr", instruction, K);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
